exp2_rr_scheduler: RTL and testbench
====================================

// Module: exp2_rr_scheduler
// PURPOSE
//  Shares one pipelined 2^x FP32 unit among NUM_REQ requesters with valid/ready handshakes.
//  - Round-robin issue of one operand per cycle.
//  - Tags each issued operand and routes the result back to its requester.
//  - Stalls the whole unit (drives its en) when the result at its output is not accepted.
//  - Drain control quiesces the unit before a LUT reload or power-down.
// PARAMETERS
//  NUM_REQ     4    number of requesters (2..8)
//  DATA_WIDTH  32   operand/result width (FP32)
//  PIPE_LAT    6    unit latency in enabled cycles, u_vld_in -> u_vld_out
//  ID_W        $clog2(NUM_REQ)  tag width (derived, not overridable)
// PORTS
//  clk         in   1                  clock, rising edge
//  rst_n       in   1                  asynchronous reset, active-low
//  req_valid   in   NUM_REQ            per-requester operand valid
//  req_data    in   NUM_REQ*DATA_WIDTH operands packed; requester i at [i*DW +: DW]
//  req_ready   out  NUM_REQ            one-hot issue acknowledge
//  rsp_valid   out  NUM_REQ            one-hot result valid, for the tagged owner
//  rsp_data    out  DATA_WIDTH         result, shared by all requesters
//  rsp_ready   in   NUM_REQ            per-requester result accept
//  drain_req   in   1                  level: stop issuing and empty the unit
//  drain_done  out  1                  level: unit is empty and issue is halted
//  u_operand   out  DATA_WIDTH         to unit Oprand_A
//  u_vld_in    out  1                  to unit vld_in
//  u_en        out  1                  to unit en (global pipeline enable)
//  u_result    in   DATA_WIDTH         from unit Result
//  u_vld_out   in   1                  from unit vld_out
// BEHAVIOUR
//  Reset values: rr_ptr=0, tag pipe all 0, inflight=0, state=RUN, drain_done=0.
//  Combinational outputs at reset: req_ready=0, rsp_valid=0, u_vld_in=0, u_en=1.
//  Stall:
//  - tag_out = last stage of the tag pipe.
//  - u_en = !(u_vld_out && !rsp_ready[tag_out]), combinational.
//  - While stalled, the unit and the tag pipe both hold.
//  Response:
//  - rsp_valid[i] = u_vld_out && (tag_out==i).
//  - rsp_data = u_result.
//  - A response is held stable until it is accepted; no response is ever dropped.
//  Issue:
//  - Issue happens only in state RUN, with u_en=1 and any req_valid set.
//  - Grant goes to the first valid requester at or after rr_ptr, in cyclic order.
//  - req_ready[g]=1, u_vld_in=1, u_operand=req_data[g].
//  - On issue: rr_ptr <= (g+1) mod NUM_REQ. Otherwise rr_ptr holds.
//  - When there is no issue: u_vld_in=0 and u_operand=0.
//  - The same requester may issue back-to-back only if no other requester is valid.
//  Tag pipe:
//  - PIPE_LAT x ID_W shift register; stage0 <= g.
//  - Shifts only when u_en=1, so it stays aligned with vld_out.
//  inflight counter, width $clog2(PIPE_LAT+1):
//  - +1 on issue; -1 on retire (u_vld_out && rsp_ready[tag_out]).
//  - Issue and retire in the same cycle: counter unchanged.
//  - Never exceeds PIPE_LAT; a violation is an assertion failure.
//  FSM (registered state):
//  - RUN  : drain_req=1 -> DRAIN. No grant in the cycle drain_req is first seen high.
//  - DRAIN: no grants; when inflight==0 -> HALT.
//  - HALT : drain_done=1; drain_req=0 -> RUN, with drain_done=0 in the same cycle.
//  - drain_req dropped while in DRAIN: -> RUN, with no drain_done pulse.
//  Mid-operation reset: every in-flight op and tag is discarded; the unit is reset by the same rst_n.
// STRUCTURE
//  Package exp2_sched_pkg:
//  - state enum {ST_RUN, ST_DRAIN, ST_HALT}.
//  - FP32 constants: FP_ONE 32'h3F800000, FP_INF 32'h7F800000, FP_ZERO 32'h0.
//  Sub-module rr_arbiter #(N): inputs req and ptr; outputs one-hot gnt and any.
//  - Purely combinational.
//  - Reused by the other shared-FPU schedulers.
//  Tag pipe, counter and FSM live in the top module; the unit is instantiated by the parent.
// TESTING (bench instantiates the real 2^x unit behind the scheduler)
//  1 Single op: req0 sends 32'h00000000 -> rsp_valid[0] exactly PIPE_LAT cycles later;
//    rsp_data=32'h3F800000.
//  2 Fairness: all 4 requesters valid continuously for 16 cycles -> grants 0,1,2,3,0,...;
//    each requester receives 4 results, in order.
//  3 Tag routing: req1=32'h43000000, req2=32'hC3000000 -> rsp_valid[1] with 32'h7F800000,
//    then rsp_valid[2] with 32'h00000000.
//  4 Backpressure: rsp_ready[1]=0 for 10 cycles while 3 ops are queued -> u_en=0,
//    rsp_data stable, no new grants; after release all 3 results are delivered with no loss.
//  5 Drain: drain_req=1 with 5 ops in flight -> no grants; drain_done=1 after the
//    last retire; drain_req=0 -> issue resumes next cycle.
//  6 Reset mid-stream: rst_n=0 with 4 ops in flight -> all outputs at reset values;
//    after release no stale rsp_valid appears.

Source files
------------

// File: rtl/exp2_sched_pkg.sv
// Shared types and FP32 constants for the exp2 round-robin scheduler.
`timescale 1ns/1ps
package exp2_sched_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALT
  } sched_state_e;

  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_INF  = 32'h7F80_0000;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr_i.
`timescale 1ns/1ps
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic                 any_o
);

  localparam int unsigned PtrW = $clog2(N);

  // Scan cyclically from ptr_i; the first set request wins.
  always_comb begin
    int unsigned sum;
    logic [PtrW-1:0] idx;
    gnt_o = '0;
    any_o = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      sum = 32'(ptr_i) + off;
      if (sum >= N) sum = sum - N;
      idx = PtrW'(sum);
      if (!any_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exp2_rr_scheduler.sv
// Shares one pipelined 2^x FP32 unit among NUM_REQ requesters. Issues one operand per
// cycle in round-robin order, tags it, and routes the result back to its owner. The
// whole unit stalls while the result at its output is not accepted.
`timescale 1ns/1ps
module exp2_rr_scheduler
  import exp2_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PIPE_LAT   = 6
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  input  logic [NUM_REQ-1:0]            rsp_ready_i,
  input  logic                          drain_req_i,
  output logic                          drain_done_o,
  output logic [DATA_WIDTH-1:0]         u_operand_o,
  output logic                          u_vld_in_o,
  output logic                          u_en_o,
  input  logic [DATA_WIDTH-1:0]         u_result_i,
  input  logic                          u_vld_out_i
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(PIPE_LAT + 1);

  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    tag_q [PIPE_LAT];
  logic [CNT_W-1:0]   inflight_q, inflight_d;
  sched_state_e       state_q, state_d;

  logic [NUM_REQ-1:0] gnt;
  logic               gnt_any;
  logic [ID_W-1:0]    gnt_idx;
  logic [ID_W-1:0]    tag_out;
  logic               issue;
  logic               retire;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .any_o (gnt_any)
  );

  assign tag_out    = tag_q[PIPE_LAT-1];
  assign rsp_data_o = u_result_i;
  // Stall only when the unit presents a result its owner does not take.
  assign u_en_o     = !(u_vld_out_i && !rsp_ready_i[tag_out]);
  assign retire     = u_vld_out_i && rsp_ready_i[tag_out];
  // Drain request blocks issue already in the cycle it is first seen.
  assign issue      = (state_q == ST_RUN) && !drain_req_i && u_en_o && gnt_any;

  // One-hot grant to binary index.
  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_idx = ID_W'(i);
    end
  end

  // Issue handshake and operand mux.
  always_comb begin
    req_ready_o = issue ? gnt : '0;
    u_vld_in_o  = issue;
    u_operand_o = DATA_WIDTH'(FP_ZERO);
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (issue && gnt[i]) u_operand_o = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Result routing to the tagged owner.
  always_comb begin
    rsp_valid_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_valid_o[i] = u_vld_out_i && (tag_out == ID_W'(i));
    end
  end

  // Next pointer, in-flight count and drain FSM.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    inflight_d = inflight_q;
    state_d    = state_q;
    if (issue) begin
      rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end
    unique case ({issue, retire})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
    unique case (state_q)
      ST_RUN:   if (drain_req_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!drain_req_i)            state_d = ST_RUN;
        else if (inflight_q == '0)   state_d = ST_HALT;
      end
      ST_HALT:  if (!drain_req_i) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Done drops combinationally with drain_req so the resume cycle never reports done.
  assign drain_done_o = (state_q == ST_HALT) && drain_req_i;

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      inflight_q <= '0;
      state_q    <= ST_RUN;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      inflight_q <= inflight_d;
      state_q    <= state_d;
    end
  end

  // Tag pipe; advances only with the unit so tag_out lines up with u_vld_out_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < PIPE_LAT; i++) tag_q[i] <= '0;
    end else if (u_en_o) begin
      tag_q[0] <= gnt_idx;
      for (int unsigned i = 1; i < PIPE_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

`ifndef SYNTHESIS
  inflight_bound_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    inflight_q <= CNT_W'(PIPE_LAT));
`endif

endmodule

// File: tb/tb_exp2_rr_scheduler.sv
// Bench for exp2_rr_scheduler with a behavioural pipelined 2^x unit behind it.
`timescale 1ns/1ps
module tb_exp2_rr_scheduler;
  import exp2_sched_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned L  = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_data;
  logic [NR-1:0]    rsp_ready;
  logic             drain_req;
  logic             drain_done;
  logic [DW-1:0]    u_operand;
  logic             u_vld_in;
  logic             u_en;
  logic [DW-1:0]    u_result;
  logic             u_vld_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  exp2_rr_scheduler #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .PIPE_LAT   (L)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .rsp_valid_o  (rsp_valid),
    .rsp_data_o   (rsp_data),
    .rsp_ready_i  (rsp_ready),
    .drain_req_i  (drain_req),
    .drain_done_o (drain_done),
    .u_operand_o  (u_operand),
    .u_vld_in_o   (u_vld_in),
    .u_en_o       (u_en),
    .u_result_i   (u_result),
    .u_vld_out_i  (u_vld_out)
  );

  // 2^x for integer-valued operands (fractional inputs are not exercised).
  function automatic logic [31:0] exp2_model(input logic [31:0] x);
    logic [7:0]  e;
    logic [23:0] sig;
    int          n;
    e   = x[30:23];
    sig = {1'b1, x[22:0]};
    if (e == 8'd0) return FP_ONE;
    if (e >= 8'd134) return x[31] ? FP_ZERO : FP_INF;
    if (e < 8'd127) return FP_ONE;
    n = int'(sig >> (150 - int'(e)));
    if (x[31]) n = -n;
    if (n < -126) return FP_ZERO;
    return {1'b0, 8'(127 + n), 23'h0};
  endfunction

  function automatic logic [31:0] fp_of_int(input int n);
    int mag;
    int p;
    if (n == 0) return 32'h0;
    mag = (n < 0) ? -n : n;
    p = 0;
    for (int b = 0; b < 31; b++) if (mag[b]) p = b;
    return {(n < 0), 8'(127 + p), 23'(mag << (23 - p))};
  endfunction

  function automatic logic [31:0] pow2(input int n);
    return {1'b0, 8'(127 + n), 23'h0};
  endfunction

  // Behavioural unit: L enabled stages, reset by the same rst_n.
  logic [L-1:0]  m_vld;
  logic [31:0]   m_dat [L];
  assign u_vld_out = m_vld[L-1];
  assign u_result  = m_dat[L-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld <= '0;
      for (int i = 0; i < L; i++) m_dat[i] <= '0;
    end else if (u_en) begin
      m_vld    <= {m_vld[L-2:0], u_vld_in};
      m_dat[0] <= exp2_model(u_operand);
      for (int i = 1; i < L; i++) m_dat[i] <= m_dat[i-1];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int r, input logic [31:0] d);
    req_data[r*DW +: DW] = d;
  endtask

  typedef struct {
    int          req;
    logic [31:0] operand;
    logic [31:0] exp_result;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt [NR];
    int rcv [NR];
    int early;
    int w;
    int got;
    int gnt_err;
    int stale;
    bit done;

    vecs[0] = '{0, FP_ZERO,      FP_ONE};
    vecs[1] = '{1, 32'h43000000, FP_INF};
    vecs[2] = '{2, 32'hC3000000, FP_ZERO};
    vecs[3] = '{3, 32'h3F800000, 32'h40000000};
    vecs[4] = '{0, 32'h40400000, 32'h41000000};
    vecs[5] = '{1, 32'hC0000000, 32'h3E800000};

    rst_n = 1'b0; req_valid = '0; req_data = '0; rsp_ready = '1; drain_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_u_vld_in", 32'(u_vld_in), 32'h0);
    check("rst_u_en", 32'(u_en), 32'h1);
    check("rst_drain_done", 32'(drain_done), 32'h0);
    check("rst_u_operand", u_operand, 32'h0);
    rst_n = 1'b1;
    step();

    // Fairness: all four requesters valid for 16 cycles.
    for (int i = 0; i < NR; i++) begin cnt[i] = 0; rcv[i] = 0; end
    for (int c = 0; c < 16 + L + 2; c++) begin
      if (c < 16) begin
        req_valid = '1;
        for (int i = 0; i < NR; i++) set_data(i, fp_of_int(i * 4 + cnt[i]));
      end else begin
        req_valid = '0;
      end
      #1;
      if (c < 16) check("fair_gnt", 32'(req_ready), 32'(1) << (c % 4));
      for (int i = 0; i < NR; i++) begin
        if (rsp_valid[i]) begin
          check("fair_rsp_data", rsp_data, pow2(i * 4 + rcv[i]));
          rcv[i]++;
        end
        if (req_ready[i]) cnt[i]++;
      end
      step();
    end
    for (int i = 0; i < NR; i++) check("fair_rsp_count", 32'(rcv[i]), 32'd4);

    // Single-op vectors: grant, exact latency and result value.
    foreach (vecs[v]) begin
      req_valid = '0;
      req_valid[vecs[v].req] = 1'b1;
      set_data(vecs[v].req, vecs[v].operand);
      #1;
      check("vec_gnt", 32'(req_ready), 32'(1) << vecs[v].req);
      step();
      req_valid = '0;
      early = 0;
      for (int k = 1; k <= L; k++) begin
        #1;
        if (k < L) begin
          if (rsp_valid != '0) early++;
        end else begin
          check("vec_rsp_valid", 32'(rsp_valid), 32'(1) << vecs[v].req);
          check("vec_rsp_data", rsp_data, vecs[v].exp_result);
        end
        step();
      end
      check("vec_no_early_rsp", 32'(early), 32'd0);
    end

    // Tag routing with two ops in flight together.
    req_valid = 4'b0010; set_data(1, 32'h43000000);
    step();
    req_valid = 4'b0100; set_data(2, 32'hC3000000);
    step();
    req_valid = '0;
    repeat (L - 2) step();
    #1;
    check("tag_rsp1_valid", 32'(rsp_valid), 32'h2);
    check("tag_rsp1_data", rsp_data, FP_INF);
    step();
    #1;
    check("tag_rsp2_valid", 32'(rsp_valid), 32'h4);
    check("tag_rsp2_data", rsp_data, FP_ZERO);
    step();

    // Backpressure: requester 1 withholds rsp_ready with three ops queued.
    rsp_ready = 4'b1101;
    for (int k = 0; k < 3; k++) begin
      req_valid = 4'b0010; set_data(1, fp_of_int(k + 1));
      #1;
      check("bp_gnt", 32'(req_ready), 32'h2);
      step();
    end
    req_valid = '0;
    w = 3;
    #1;
    while (!rsp_valid[1] && w < 3 + 2 * L) begin
      step();
      #1;
      w++;
    end
    check("bp_first_rsp_cycle", 32'(w), 32'(L));
    req_valid = 4'b0001; set_data(0, FP_ZERO);
    for (int s = 0; s < 10; s++) begin
      #1;
      check("bp_u_en", 32'(u_en), 32'h0);
      check("bp_rsp_data_stable", rsp_data, 32'h40000000);
      check("bp_no_gnt", 32'(req_ready), 32'h0);
      check("bp_rsp_valid_held", 32'(rsp_valid), 32'h2);
      step();
    end
    req_valid = '0;
    rsp_ready = '1;
    got = 0;
    for (int c = 0; c < 3 * L && got < 3; c++) begin
      #1;
      if (rsp_valid[1]) begin
        check("bp_release_data", rsp_data, pow2(got + 1));
        got++;
      end
      step();
    end
    check("bp_release_count", 32'(got), 32'd3);
    repeat (L) step();

    // Drain with five ops in flight.
    for (int k = 0; k < 5; k++) begin
      req_valid = 4'b0100; set_data(2, fp_of_int(k + 1));
      #1;
      check("dr_gnt", 32'(req_ready), 32'h4);
      step();
    end
    req_valid = 4'b1000; set_data(3, FP_ZERO);
    drain_req = 1'b1;
    got = 0; gnt_err = 0; done = 1'b0;
    for (int c = 0; c < 4 * L && !done; c++) begin
      #1;
      if (c == 0) check("dr_first_cycle_gnt", 32'(req_ready), 32'h0);
      if (rsp_valid[2]) begin
        check("dr_rsp_data", rsp_data, pow2(got + 1));
        got++;
      end
      if (req_ready != '0) gnt_err++;
      if (drain_done) begin
        done = 1'b1;
        check("dr_done_after_last_retire", 32'(got), 32'd5);
      end else begin
        step();
      end
    end
    check("dr_done_seen", 32'(done), 32'h1);
    check("dr_no_gnt_while_draining", 32'(gnt_err), 32'd0);
    step();
    #1;
    check("dr_halt_done_held", 32'(drain_done), 32'h1);
    check("dr_halt_no_gnt", 32'(req_ready), 32'h0);
    step();
    drain_req = 1'b0;
    #1;
    check("dr_release_done_low", 32'(drain_done), 32'h0);
    check("dr_release_same_cycle_no_gnt", 32'(req_ready), 32'h0);
    step();
    #1;
    check("dr_resume_gnt", 32'(req_ready), 32'h8);
    step();
    req_valid = '0;
    repeat (L + 2) step();

    // Reset with four ops in flight.
    for (int k = 0; k < 4; k++) begin
      req_valid = 4'b0001; set_data(0, fp_of_int(k + 1));
      step();
    end
    req_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_req_ready", 32'(req_ready), 32'h0);
    check("mrst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("mrst_u_vld_in", 32'(u_vld_in), 32'h0);
    check("mrst_u_en", 32'(u_en), 32'h1);
    check("mrst_drain_done", 32'(drain_done), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 2 * L; c++) begin
      step();
      #1;
      if (rsp_valid != '0) stale++;
    end
    check("mrst_no_stale_rsp", 32'(stale), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
